// File: rtl/scc_mem_pkg.sv
// Shared types for the SCC memory arbiter: FSM states, owner encoding, err_bits indices.
package scc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int ERR_IF_BIT = 0;
    localparam int ERR_D_BIT  = 1;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/scc_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter; slave = arbiter view.
interface scc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/scc_mem_lat_cnt.sv
// Loadable down-counter timing the memory latency; zero flags terminal count.
module scc_mem_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/scc_mem_arbiter.sv
// Single-port memory arbiter/sequencer for fetch and load/store.
// Optional round-robin arbitration: define SCC_MEM_ARB_RR_EN.
module scc_mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               halt,
    scc_mem_arbiter_if.slave   bus,
    output logic               busy,
    output logic [1:0]         err_bits
);
    localparam int                 CNT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        err_q, err_d;

    logic              win, if_cand, d_cand;
    logic              gnt_if, gnt_d, any_gnt;
    logic              cnt_en, cnt_zero;
    logic [ADDR_W-1:0] sel_addr;

    assign win     = clk_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign if_cand = win && bus.if_req && !halt;
    assign d_cand  = win && bus.d_req;

`ifdef SCC_MEM_ARB_RR_EN
    owner_t last_q, last_d;

    // On contention the requester that did not win last time takes the slot.
    always_comb begin
        gnt_d  = d_cand && !(if_cand && (last_q == OWN_D));
        gnt_if = if_cand && !gnt_d;
        last_d = last_q;
        if (gnt_d) begin
            last_d = OWN_D;
        end else if (gnt_if) begin
            last_d = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt_d  = d_cand;
        gnt_if = if_cand && !d_cand;
    end
`endif

    assign any_gnt  = gnt_d || gnt_if;
    assign sel_addr = gnt_d ? bus.d_addr : bus.if_addr;
    assign cnt_en   = clk_en && (state_q == ST_ACCESS);

    scc_mem_lat_cnt #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .load     (any_gnt),
        .load_val (CNT_LOAD),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;

        if (clk_en) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: state_d = any_gnt ? ST_ACCESS : ST_IDLE;
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state_d = ST_DONE;
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = bus.mem_rdata;
                        end else if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Misaligned requests are flagged but still serviced at the word address.
        if (any_gnt) begin
            owner_d = gnt_d ? OWN_D : OWN_IF;
            we_d    = gnt_d && bus.d_we;
            addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
            if (gnt_d) begin
                wdata_d = bus.d_wdata;
            end
            if (misaligned(sel_addr[1:0])) begin
                if (gnt_d) begin
                    err_d[ERR_D_BIT] = 1'b1;
                end else begin
                    err_d[ERR_IF_BIT] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign bus.d_rvalid  = (state_q == ST_DONE) && (owner_q == OWN_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_bits      = err_q;
endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Self-checking bench for scc_mem_arbiter: vector table, scoreboard, corner sequences.
module tb_scc_mem_arbiter;
    import scc_mem_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic halt;
    logic busy;
    logic [1:0] err_bits;

    scc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    scc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .halt     (halt),
        .bus      (bus),
        .busy     (busy),
        .err_bits (err_bits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory seen by the DUT, and the bench's own reference copy
    logic [31:0] phys  [64];
    logic [31:0] model [64];
    assign bus.mem_rdata = phys[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst && clk_en && bus.mem_en && bus.mem_we)
            phys[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic        own;
        logic        we;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sb[$];
    int          ecyc = 0;
    logic [31:0] last_load = '0;

    always @(posedge clk) if (rst && clk_en) ecyc++;

    always @(negedge rst) begin
        sb.delete();
        last_load = '0;
    end

    always @(negedge clk) begin
        sb_t e;
        if (rst && clk_en) begin
            if (bus.if_gnt && bus.d_gnt) chk("dual_gnt", 1, 0);
            if (bus.if_rvalid && bus.d_rvalid) chk("dual_rvalid", 1, 0);
            if (bus.d_gnt) begin
                e.own  = 1'b1;
                e.we   = bus.d_we;
                e.data = model[bus.d_addr[7:2]];
                e.due  = ecyc + LAT + 1;
                if (bus.d_we) model[bus.d_addr[7:2]] = bus.d_wdata;
                sb.push_back(e);
            end else if (bus.if_gnt) begin
                e.own  = 1'b0;
                e.we   = 1'b0;
                e.data = model[bus.if_addr[7:2]];
                e.due  = ecyc + LAT + 1;
                sb.push_back(e);
            end
            if (bus.d_rvalid || bus.if_rvalid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rvalid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_owner", {63'd0, bus.d_rvalid}, {63'd0, e.own});
                    chk("sb_time", 64'(ecyc), 64'(e.due));
                    if (e.own && e.we) begin
                        chk("sb_store_keeps_rdata", bus.d_rdata, last_load);
                    end else if (e.own) begin
                        chk("sb_d_rdata", bus.d_rdata, e.data);
                        last_load = e.data;
                    end else begin
                        chk("sb_if_rdata", bus.if_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic do_access(input logic own, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] maddr,
                             output logic [31:0] rdata, output int lat);
        bit got;
        maddr = '0; rdata = '0; lat = 0;
        @(posedge clk); #1;
        if (own) begin
            bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1; bus.if_addr = addr;
        end
        got = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (own ? bus.d_gnt : bus.if_gnt) begin got = 1; break; end
        end
        if (!got) begin
            chk("gnt_timeout", 0, 1);
            bus.d_req = 0; bus.if_req = 0;
            return;
        end
        @(posedge clk); #1;
        bus.d_req = 0; bus.if_req = 0;
        @(negedge clk);
        maddr = bus.mem_addr;
        lat = 1;
        got = 0;
        for (int n = 0; n < 30; n++) begin
            if (clk_en && (own ? bus.d_rvalid : bus.if_rvalid)) begin got = 1; break; end
            @(negedge clk);
            lat++;
        end
        if (!got) chk("rvalid_timeout", 0, 1);
        rdata = own ? bus.d_rdata : bus.if_rdata;
    endtask

    // Both request together; first winner checked, loser must be granted in DONE.
    task automatic contend(input logic exp_d_first);
        bit got;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h0C;
        bus.d_req  = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        @(negedge clk);
        chk("contend_d_gnt", {63'd0, bus.d_gnt}, {63'd0, exp_d_first});
        chk("contend_if_gnt", {63'd0, bus.if_gnt}, {63'd0, !exp_d_first});
        @(posedge clk); #1;
        if (exp_d_first) bus.d_req = 0; else bus.if_req = 0;
        got = 0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (exp_d_first ? bus.if_gnt : bus.d_gnt) begin
                got = 1;
                chk("contend_loser_in_done", 64'(n), 64'(LAT + 1));
                break;
            end
        end
        if (!got) chk("contend_loser_timeout", 0, 1);
        @(posedge clk); #1;
        bus.d_req = 0; bus.if_req = 0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    typedef struct {
        logic        own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] ma, rd;
        int          lat, dv_cnt;
        bit          saw_dgnt, saw_we;

        for (int i = 0; i < 64; i++) begin
            phys[i]  = 32'hA000_0000 + 32'(i);
            model[i] = 32'hA000_0000 + 32'(i);
        end
        phys[4] = 32'hDEAD_BEEF; model[4] = 32'hDEAD_BEEF;

        vecs[0] = '{1'b1, 1'b0, 32'h00, 32'h0,          32'h00, 32'hA000_0000};
        vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,          32'h04, 32'hA000_0001};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 32'h1234_5678,  32'h08, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h08, 32'h0,          32'h08, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h08, 32'h0,          32'h08, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h3C, 32'h0,          32'h3C, 32'hA000_000F};
        vecs[6] = '{1'b1, 1'b1, 32'h3C, 32'hCAFE_F00D,  32'h3C, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h3C, 32'h0,          32'h3C, 32'hCAFE_F00D};

        rst = 0; clk_en = 1; halt = 0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        #1;
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_mem_en", {63'd0, bus.mem_en}, 0);
        chk("rst_err", {62'd0, err_bits}, 0);
        chk("rst_rvalid", {62'd0, bus.if_rvalid, bus.d_rvalid}, 0);
        chk("rst_d_rdata", {32'd0, bus.d_rdata}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // Single load with exact cycle-by-cycle timing
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        @(negedge clk);
        chk("t1_d_gnt", {63'd0, bus.d_gnt}, 1);
        @(posedge clk); #1 bus.d_req = 0;
        @(negedge clk);
        chk("t1_mem_en_t1", {63'd0, bus.mem_en}, 1);
        chk("t1_mem_addr", {32'd0, bus.mem_addr}, 32'h10);
        @(negedge clk);
        chk("t1_mem_en_t2", {63'd0, bus.mem_en}, 1);
        chk("t1_busy", {63'd0, busy}, 1);
        @(negedge clk);
        chk("t1_mem_en_t3", {63'd0, bus.mem_en}, 0);
        chk("t1_d_rvalid", {63'd0, bus.d_rvalid}, 1);
        chk("t1_d_rdata", {32'd0, bus.d_rdata}, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_rvalid_pulse", {63'd0, bus.d_rvalid}, 0);
        chk("t1_idle", {63'd0, busy}, 0);

        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].own, vecs[i].we, vecs[i].addr, vecs[i].wdata, ma, rd, lat);
            chk($sformatf("vec%0d_maddr", i), {32'd0, ma}, {32'd0, vecs[i].exp_maddr});
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT + 1));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
        end

        contend(1'b1);
        do_access(1'b1, 1'b0, 32'h00, 32'h0, ma, rd, lat);
`ifdef SCC_MEM_ARB_RR_EN
        contend(1'b0);
`else
        contend(1'b1);
`endif

        // Halt blocks fetch grants but a store still completes
        @(posedge clk); #1;
        halt = 1; bus.if_req = 1; bus.if_addr = 32'h14;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h5A5A_0020;
        saw_dgnt = 0; saw_we = 0; dv_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("halt_if_gnt", {63'd0, bus.if_gnt}, 0);
            if (bus.d_gnt) saw_dgnt = 1;
            if (bus.mem_we && bus.mem_addr == 32'h20) saw_we = 1;
            if (bus.d_rvalid) dv_cnt++;
            @(posedge clk); #1;
            if (saw_dgnt) bus.d_req = 0;
        end
        chk("halt_store_we", {63'd0, saw_we}, 1);
        chk("halt_store_rvalid", 64'(dv_cnt), 1);
        chk("halt_store_mem", {32'd0, phys[8]}, 32'h5A5A_0020);
        bus.if_req = 0; halt = 0;
        do_access(1'b0, 1'b0, 32'h14, 32'h0, ma, rd, lat);
        chk("after_halt_fetch", {32'd0, rd}, 32'hA000_0005);

        // Misaligned fetch, then aligned and misaligned data accesses
        do_access(1'b0, 1'b0, 32'h06, 32'h0, ma, rd, lat);
        chk("misal_if_maddr", {32'd0, ma}, 32'h04);
        chk("misal_if_rdata", {32'd0, rd}, 32'hA000_0001);
        chk("misal_if_err", {62'd0, err_bits}, 2'b01);
        do_access(1'b1, 1'b0, 32'h18, 32'h0, ma, rd, lat);
        chk("err_sticky", {62'd0, err_bits}, 2'b01);
        do_access(1'b1, 1'b0, 32'h1B, 32'h0, ma, rd, lat);
        chk("misal_d_maddr", {32'd0, ma}, 32'h18);
        chk("misal_d_err", {62'd0, err_bits}, 2'b11);

        // Three-cycle stall in ACCESS with a fetch waiting
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h04;
        @(negedge clk);
        chk("stall_d_gnt", {63'd0, bus.d_gnt}, 1);
        @(posedge clk); #1 bus.d_req = 0; bus.if_req = 1; bus.if_addr = 32'h28;
        @(negedge clk);
        @(posedge clk); #1 clk_en = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("stall_mem_en", {63'd0, bus.mem_en}, 1);
            chk("stall_mem_addr", {32'd0, bus.mem_addr}, 32'h04);
            chk("stall_no_gnt", {62'd0, bus.if_gnt, bus.d_gnt}, 0);
        end
        @(posedge clk); #1 clk_en = 1;
        @(negedge clk);
        chk("stall_not_yet", {63'd0, bus.d_rvalid}, 0);
        @(negedge clk);
        chk("stall_rvalid_late", {63'd0, bus.d_rvalid}, 1);
        chk("stall_rdata", {32'd0, bus.d_rdata}, 32'hA000_0001);
        chk("stall_if_gnt_done", {63'd0, bus.if_gnt}, 1);
        @(posedge clk); #1 bus.if_req = 0;
        repeat (LAT + 2) @(negedge clk);

        // Reset mid-ACCESS drops the access
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h00;
        @(negedge clk);
        @(posedge clk); #1 bus.d_req = 0;
        @(negedge clk);
        chk("rstacc_mem_en_before", {63'd0, bus.mem_en}, 1);
        #2 rst = 0;
        #1;
        chk("rstacc_mem_en", {63'd0, bus.mem_en}, 0);
        chk("rstacc_busy", {63'd0, busy}, 0);
        chk("rstacc_err", {62'd0, err_bits}, 0);
        chk("rstacc_mem_addr", {32'd0, bus.mem_addr}, 0);
        @(posedge clk); #1 rst = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rstacc_no_rvalid", {62'd0, bus.if_rvalid, bus.d_rvalid}, 0);
        end

        do_access(1'b1, 1'b0, 32'h3C, 32'h0, ma, rd, lat);
        chk("post_rst_load", {32'd0, rd}, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
